// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter:
// parity modes, shifter state encoding and the default divisor.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int BAUD_DIV_4800_50M = 10416;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } tx_state_e;

    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: ticks every max(div,1)+1 cycles,
// restartable so each frame begins on a fresh count.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_eff;

    always_comb begin
        // A zero divisor would give 1-cycle bits; clamp to 2.
        div_eff = (div == '0) ? DIV_W'(1) : div;
        tick    = (cnt_q == div_eff);
        cnt_d   = cnt_q + DIV_W'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with run-time divisor, parity and stop-bit
// selection, and a one-entry holding buffer for gapless frames.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int   DATA_BITS  = 8,
    parameter int   DIV_W      = 16,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    input  logic                 tx_en,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 tx
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] buf_q, buf_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 buf_full_q, buf_full_d;
    logic [3:0]           bit_q, bit_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [1:0]           pmode_q, pmode_d;
    logic                 stop2_q, stop2_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;

    logic tick;
    logic restart;
    logic accept;
    logic last_stop;
    logic start_ok;

    uart_baud_gen #(
        .DIV_W(DIV_W)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .div     (div_q),
        .tick    (tick)
    );

    assign accept    = in_valid && !buf_full_q;
    assign last_stop = tick
                     && ((state_q == S_STOP1 && !stop2_q)
                     ||  (state_q == S_STOP2));
    assign start_ok  = buf_full_q && tx_en
                     && ((state_q == S_IDLE) || last_stop);

    assign in_ready   = !buf_full_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = last_stop;
    assign tx         = tx_q;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        sh_d       = sh_q;
        bit_d      = bit_q;
        div_d      = div_q;
        pmode_d    = pmode_q;
        stop2_d    = stop2_q;
        par_d      = par_q;
        tx_d       = tx_q;
        restart    = 1'b0;

        if (accept) begin
            buf_d      = in_data;
            buf_full_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    tx_d    = sh_q[0];
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        if (par_enabled(pmode_q)) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP1;
                            tx_d    = IDLE_LEVEL;
                        end
                    end else begin
                        sh_d  = {1'b0, sh_q[DATA_BITS-1:1]};
                        tx_d  = sh_q[1];
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP1;
                    tx_d    = IDLE_LEVEL;
                end
            end
            S_STOP1: begin
                if (tick && stop2_q) begin
                    state_d = S_STOP2;
                end
            end
            S_STOP2: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (last_stop) begin
            state_d = S_IDLE;
            tx_d    = IDLE_LEVEL;
        end

        // Frame config is sampled only here, so mid-frame
        // changes apply to the next frame.
        if (start_ok) begin
            state_d    = S_START;
            tx_d       = ~IDLE_LEVEL;
            sh_d       = buf_q;
            par_d      = (^buf_q) ^ (parity_mode == PAR_ODD);
            div_d      = baud_div;
            pmode_d    = parity_mode;
            stop2_d    = stop2;
            buf_full_d = 1'b0;
            restart    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            sh_q       <= '0;
            bit_q      <= '0;
            div_q      <= '0;
            pmode_q    <= PAR_NONE;
            stop2_q    <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= IDLE_LEVEL;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            sh_q       <= sh_d;
            bit_q      <= bit_d;
            div_q      <= div_d;
            pmode_q    <= pmode_d;
            stop2_q    <= stop2_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
        end
    end

endmodule
